// File: rtl/dctq_block_scheduler.sv
// Frame-level sequencer for the DCTQ processor: streams 64 pixels per 8x8 block into the
// datapath, counts returned coefficients and throttles against output FIFO credits.
module dctq_block_scheduler #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned NBLK_W     = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NBLK_W-1:0] cfg_nblocks,
  input  logic              frame_start,
  output logic              frame_busy,
  output logic              frame_done,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              dctq_start,
  output logic              dctq_hold,
  input  logic              dctq_valid,
  input  logic              credit_ret,
  output logic              credit_err,
  output logic [NBLK_W-1:0] blk_in_cnt,
  output logic [NBLK_W-1:0] blk_out_cnt
);

  localparam int unsigned CredW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CredW-1:0] CredMax = CredW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  state_e            state;
  logic [NBLK_W-1:0] nblk;
  logic [5:0]        pix_cnt;
  logic [5:0]        coef_cnt;
  logic [CredW-1:0]  credits;

  logic              in_load;
  logic              active;
  logic              cred_empty;
  logic              pix_acc;
  logic              coef_acc;
  logic              pix_wrap;
  logic              coef_wrap;
  logic [NBLK_W-1:0] blk_in_nxt;
  logic [NBLK_W-1:0] blk_out_nxt;

  always_comb begin
    in_load     = (state == StLoad);
    active      = in_load | (state == StDrain);
    cred_empty  = (credits == '0);
    pix_ready   = in_load & ~cred_empty;
    // In LOAD the datapath advances only together with an accepted pixel.
    dctq_hold   = (in_load & ~pix_valid) | cred_empty;
    pix_acc     = pix_valid & pix_ready;
    coef_acc    = active & dctq_valid & ~dctq_hold;
    pix_wrap    = pix_acc & (pix_cnt == 6'd63);
    coef_wrap   = coef_acc & (coef_cnt == 6'd63);
    blk_in_nxt  = blk_in_cnt + NBLK_W'(1);
    blk_out_nxt = blk_out_cnt + NBLK_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      nblk        <= '0;
      pix_cnt     <= '0;
      coef_cnt    <= '0;
      blk_in_cnt  <= '0;
      blk_out_cnt <= '0;
      credits     <= CredMax;
      credit_err  <= 1'b0;
      dctq_start  <= 1'b0;
      frame_busy  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (frame_start) begin
            nblk        <= cfg_nblocks;
            pix_cnt     <= '0;
            coef_cnt    <= '0;
            blk_in_cnt  <= '0;
            blk_out_cnt <= '0;
            credit_err  <= 1'b0;
            if (cfg_nblocks == '0) begin
              state      <= StDone;
              frame_done <= 1'b1;
            end else begin
              state      <= StLoad;
              dctq_start <= 1'b1;
              frame_busy <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (pix_acc) begin
            pix_cnt <= pix_cnt + 6'd1;
            if (pix_wrap) begin
              blk_in_cnt <= blk_in_nxt;
              if (blk_in_nxt == nblk) begin
                state      <= StDrain;
                dctq_start <= 1'b0;
              end
            end
          end
        end
        StDrain: begin
          // Look ahead on the final wrap so DONE follows the last coefficient directly.
          if ((blk_out_cnt == nblk) || (coef_wrap && (blk_out_nxt == nblk))) begin
            state      <= StDone;
            frame_busy <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        StDone: begin
          state      <= StIdle;
          frame_done <= 1'b0;
        end
        default: state <= StIdle;
      endcase

      if (coef_acc) begin
        coef_cnt <= coef_cnt + 6'd1;
        if (coef_wrap) begin
          blk_out_cnt <= blk_out_nxt;
        end
      end

      // Placed after the FSM so an overflow in the frame_start cycle still sticks.
      if (coef_acc && !credit_ret) begin
        credits <= credits - CredW'(1);
      end else if (credit_ret && !coef_acc) begin
        if (credits == CredMax) begin
          credit_err <= 1'b1;
        end else begin
          credits <= credits + CredW'(1);
        end
      end
    end
  end

endmodule
